// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one step per clock, then a single write-back beat toward the register file.
module mdu_iterative #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  stall,
  output logic                  busy,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data
);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_q, neg_d, rneg_q, rneg_d;
  logic [DW-1:0]         m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0]         wb_data_q, wb_data_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;

  // Operand signedness, magnitudes and divide special cases
  logic          a_signed, b_signed, a_neg, b_neg, div0, ovf;
  logic [DW-1:0] a_mag, b_mag, min_neg;
  always_comb begin
    min_neg  = {1'b1, {(DW-1){1'b0}}};
    a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = a_signed & rs1_val[DW-1];
    b_neg    = b_signed & rs2_val[DW-1];
    a_mag    = a_neg ? (~rs1_val + DW'(1)) : rs1_val;
    b_mag    = b_neg ? (~rs2_val + DW'(1)) : rs2_val;
    div0     = (rs2_val == '0);
    ovf      = !op[0] && (rs1_val == min_neg) && (rs2_val == '1);
  end

  // One iteration: {hi,lo} is the product accumulator or the remainder/quotient pair
  logic [DW:0]   mul_sum, div_sh;
  logic          div_ge;
  logic [DW-1:0] step_hi, step_lo, quo, rem;
  logic [PW-1:0] prod, prod_s;
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh  = {hi_q, lo_q[DW-1]};
    div_ge  = (div_sh >= {1'b0, m_q});
    if (op_q[2]) begin
      step_hi = div_ge ? (div_sh[DW-1:0] - m_q) : div_sh[DW-1:0];
      step_lo = {lo_q[DW-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DW:1];
      step_lo = {mul_sum[0], lo_q[DW-1:1]};
    end
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? (~prod + PW'(1)) : prod;
    quo    = neg_q ? (~step_lo + DW'(1)) : step_lo;
    rem    = rneg_q ? (~step_hi + DW'(1)) : step_hi;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    stall     = 1'b0;
    busy      = (state_q != IDLE);
    wb_we     = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) begin
          op_d      = op;
          wb_addr_d = rd_addr;
          cnt_d     = '0;
          hi_d      = '0;
          neg_d     = a_neg ^ b_neg;
          rneg_d    = a_neg;
          m_d       = op[2] ? b_mag : a_mag;
          lo_d      = op[2] ? a_mag : b_mag;
          state_d   = CALC;
          if (op[2] && div0) begin
            wb_data_d = op[1] ? rs1_val : '1;
            state_d   = DONE;
          end else if (op[2] && ovf) begin
            wb_data_d = op[1] ? '0 : rs1_val;
            state_d   = DONE;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DW - 1)) begin
          state_d = DONE;
          case (op_q)
            3'd0:             wb_data_d = prod_s[DW-1:0];
            3'd1, 3'd2, 3'd3: wb_data_d = prod_s[PW-1:DW];
            3'd4, 3'd5:       wb_data_d = quo;
            default:          wb_data_d = rem;
          endcase
        end
      end
      DONE: begin
        wb_we   = (wb_addr_q != '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule
